pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve countdown, ball motion, paddle/wall bounces and scoring.
// Everything advances on frame_tick; all outputs come straight from registers.
module pong_game_ctrl #(
  parameter int unsigned H_VIS        = 640,
  parameter int unsigned V_VIS        = 480,
  parameter int unsigned PADDLE_SIZE  = 40,
  parameter int unsigned BALL_SIZE    = 6,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [8:0] pos_l,
  input  logic [8:0] pos_r,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SERVE = 2'b01;
  localparam logic [1:0] S_PLAY  = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [9:0] X_CTR    = 10'(H_VIS / 2 - BALL_SIZE / 2);
  localparam logic [8:0] Y_CTR    = 9'(V_VIS / 2 - BALL_SIZE / 2);
  localparam logic [8:0] Y_BOT    = 9'(V_VIS - BALL_SIZE);
  localparam logic [9:0] BS10     = 10'(BALL_SIZE);
  localparam logic [9:0] HALF_PAD = 10'(PADDLE_SIZE / 2);
  localparam logic [9:0] X_L_LO   = 10'd10;
  localparam logic [9:0] X_L_HI   = 10'd16;
  localparam logic [9:0] X_L_MISS = 10'd2;
  localparam logic [9:0] X_R_LO   = 10'(H_VIS - 16);
  localparam logic [9:0] X_R_HI   = 10'(H_VIS - 10);
  localparam logic [9:0] X_R_MISS = 10'(H_VIS - 2);
  localparam logic [9:0] X_STEP   = 10'd2;
  localparam logic [8:0] Y_STEP   = 9'd1;
  localparam logic [3:0] WIN_S    = 4'(WIN_SCORE);
  localparam logic [3:0] SCORE_1  = 4'd1;

  logic             serve_q;
  logic [CNT_W-1:0] cnt;
  logic             dx;  // 1 = moving right
  logic             dy;  // 1 = moving down

  logic [1:0]       nxt_state;
  logic [9:0]       nxt_x;
  logic [8:0]       nxt_y;
  logic             nxt_en;
  logic [3:0]       nxt_sl;
  logic [3:0]       nxt_sr;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_dx;
  logic             nxt_dy;

  logic       serve_ev;
  logic       ovl_l;
  logic       ovl_r;
  logic       miss_l;
  logic       miss_r;
  logic [9:0] x_right;
  logic [9:0] hx;
  logic       hdx;
  logic [8:0] vy;
  logic       vdy;

  // Vertical overlap of the ball with a paddle; paddle top clamps at line 0.
  function automatic logic overlap(input logic [8:0] y, input logic [8:0] pos);
    logic [9:0] top;
    logic [9:0] bot;
    logic [9:0] y10;
    y10 = {1'b0, y};
    top = ({1'b0, pos} >= HALF_PAD) ? ({1'b0, pos} - HALF_PAD) : 10'd0;
    bot = {1'b0, pos} + HALF_PAD;
    return ((y10 + BS10) > top) && (y10 < bot);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ball_x  <= X_CTR;
      ball_y  <= Y_CTR;
      ball_en <= 1'b0;
      score_l <= 4'd0;
      score_r <= 4'd0;
      cnt     <= '0;
      dx      <= 1'b1;
      dy      <= 1'b1;
      serve_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      ball_x  <= nxt_x;
      ball_y  <= nxt_y;
      ball_en <= nxt_en;
      score_l <= nxt_sl;
      score_r <= nxt_sr;
      cnt     <= nxt_cnt;
      dx      <= nxt_dx;
      dy      <= nxt_dy;
      serve_q <= serve;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_x     = ball_x;
    nxt_y     = ball_y;
    nxt_en    = ball_en;
    nxt_sl    = score_l;
    nxt_sr    = score_r;
    nxt_cnt   = cnt;
    nxt_dx    = dx;
    nxt_dy    = dy;
    serve_ev  = serve & ~serve_q;
    ovl_l     = overlap(ball_y, pos_l);
    ovl_r     = overlap(ball_y, pos_r);
    x_right   = ball_x + BS10;
    miss_l    = 1'b0;
    miss_r    = 1'b0;
    hx        = ball_x;
    hdx       = dx;
    vy        = ball_y;
    vdy       = dy;

    case (state)
      S_IDLE: begin
        nxt_en = 1'b0;
        if (serve_ev) begin
          nxt_state = S_SERVE;
          nxt_cnt   = CNT_LOAD;
          nxt_x     = X_CTR;
          nxt_y     = Y_CTR;
        end
      end
      S_SERVE: begin
        nxt_x  = X_CTR;
        nxt_y  = Y_CTR;
        nxt_en = 1'b0;
        if (frame_tick) begin
          if (cnt == '0) begin
            nxt_state = S_PLAY;
            nxt_en    = 1'b1;
          end else begin
            nxt_cnt = cnt - CNT_ONE;
          end
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          // Vertical move with wall bounce applied in the same update.
          if (!dy) begin
            if (ball_y == 9'd0) begin
              vy  = Y_STEP;
              vdy = 1'b1;
            end else begin
              vy = ball_y - Y_STEP;
            end
          end else if (ball_y >= Y_BOT) begin
            vy  = ball_y - Y_STEP;
            vdy = 1'b0;
          end else begin
            vy = ball_y + Y_STEP;
          end

          // Horizontal move: paddle hit takes priority over a miss.
          if (!dx) begin
            if (ball_x >= X_L_LO && ball_x <= X_L_HI && ovl_l) begin
              hdx = 1'b1;
              hx  = ball_x + X_STEP;
            end else if (ball_x < X_L_MISS) begin
              miss_l = 1'b1;
            end else begin
              hx = ball_x - X_STEP;
            end
          end else begin
            if (x_right >= X_R_LO && x_right <= X_R_HI && ovl_r) begin
              hdx = 1'b0;
              hx  = ball_x - X_STEP;
            end else if (x_right >= X_R_MISS) begin
              miss_r = 1'b1;
            end else begin
              hx = ball_x + X_STEP;
            end
          end

          nxt_x  = hx;
          nxt_dx = hdx;
          nxt_y  = vy;
          nxt_dy = vdy;

          // Point scored: recentre and serve toward the player who conceded.
          if (miss_l || miss_r) begin
            nxt_x  = X_CTR;
            nxt_y  = Y_CTR;
            nxt_en = 1'b0;
            if (miss_l) begin
              nxt_sr = score_r + SCORE_1;
              nxt_dx = 1'b0;
            end else begin
              nxt_sl = score_l + SCORE_1;
              nxt_dx = 1'b1;
            end
            if ((miss_l && (score_r + SCORE_1) == WIN_S) ||
                (miss_r && (score_l + SCORE_1) == WIN_S)) begin
              nxt_state = S_OVER;
            end else begin
              nxt_state = S_SERVE;
              nxt_cnt   = CNT_LOAD;
            end
          end
        end
      end
      S_OVER: begin
        nxt_en = 1'b0;
        if (serve_ev) begin
          nxt_state = S_SERVE;
          nxt_cnt   = CNT_LOAD;
          nxt_sl    = 4'd0;
          nxt_sr    = 4'd0;
          nxt_x     = X_CTR;
          nxt_y     = Y_CTR;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: driver pushes expected outputs, monitor pops and compares.
// Directed game phases plus hand-computed spot checks at serve, bounces, points and reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [8:0] pos_l = 9'd0;
  logic [8:0] pos_r = 9'd0;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_en;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] state;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pos_l(pos_l), .pos_r(pos_r),
    .serve(serve), .ball_x(ball_x), .ball_y(ball_y), .ball_en(ball_en),
    .score_l(score_l), .score_r(score_r), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int due;
    int st, x, y, en, sl, sr;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  // Reference game state
  int m_st, m_x, m_y, m_en, m_sl, m_sr, m_cnt, m_dx, m_dy, m_sprev;
  bit hit_l, hit_r;
  bit ev_top, ev_bot, ev_lhit, ev_rhit, ev_lmiss, ev_rmiss;
  bit saw_top, saw_bot, saw_lhit, saw_rhit;
  int old_x;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 317; m_y = 237; m_en = 0; m_sl = 0; m_sr = 0;
    m_cnt = 0; m_dx = 1; m_dy = 1; m_sprev = 0;
  endtask

  task automatic model(input bit s, input bit t, input int pl, input int pr);
    bit ev;
    int ny, ndy, nx, ndx, topl, topr;
    bit ovl, ovr, pt_l, pt_r;
    ev = s && (m_sprev == 0);
    m_sprev = s;
    ev_top = 0; ev_bot = 0; ev_lhit = 0; ev_rhit = 0; ev_lmiss = 0; ev_rmiss = 0;
    if (ev && (m_st == 0 || m_st == 3)) begin
      if (m_st == 3) begin m_sl = 0; m_sr = 0; end
      m_st = 1; m_cnt = 60; m_x = 317; m_y = 237; m_en = 0;
    end else if (t) begin
      if (m_st == 1) begin
        if (m_cnt == 0) begin m_st = 2; m_en = 1; end
        else m_cnt--;
      end else if (m_st == 2) begin
        ny = m_y; ndy = m_dy; nx = m_x; ndx = m_dx; pt_l = 0; pt_r = 0;
        if (m_dy == 0) begin
          if (m_y == 0) begin ny = 1; ndy = 1; ev_top = 1; end
          else ny = m_y - 1;
        end else begin
          if (m_y >= 474) begin ny = m_y - 1; ndy = 0; ev_bot = 1; end
          else ny = m_y + 1;
        end
        topl = (pl > 20) ? pl - 20 : 0;
        topr = (pr > 20) ? pr - 20 : 0;
        ovl = (m_y + 6 > topl) && (m_y < pl + 20);
        ovr = (m_y + 6 > topr) && (m_y < pr + 20);
        if (m_dx == 0) begin
          if (m_x >= 10 && m_x <= 16 && ovl) begin ndx = 1; nx = m_x + 2; ev_lhit = 1; end
          else if (m_x < 2) pt_l = 1;
          else nx = m_x - 2;
        end else begin
          if (m_x + 6 >= 624 && m_x + 6 <= 630 && ovr) begin ndx = 0; nx = m_x - 2; ev_rhit = 1; end
          else if (m_x + 6 >= 638) pt_r = 1;
          else nx = m_x + 2;
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
        if (pt_l || pt_r) begin
          m_x = 317; m_y = 237; m_en = 0;
          if (pt_l) begin m_sr++; m_dx = 0; ev_lmiss = 1; end
          else begin m_sl++; m_dx = 1; ev_rmiss = 1; end
          if ((pt_l && m_sr == 9) || (pt_r && m_sl == 9)) m_st = 3;
          else begin m_st = 1; m_cnt = 60; end
        end
      end
    end
    saw_top |= ev_top; saw_bot |= ev_bot; saw_lhit |= ev_lhit; saw_rhit |= ev_rhit;
  endtask

  task automatic push_exp();
    exp_t e;
    e.due = cyc + 1;
    e.st = m_st; e.x = m_x; e.y = m_y; e.en = m_en; e.sl = m_sl; e.sr = m_sr;
    q.push_back(e);
  endtask

  task automatic step(input bit s, input bit t);
    int track;
    @(negedge clk);
    track = (m_y + 3 > 511) ? 511 : m_y + 3;
    pos_l = hit_l ? 9'(track) : 9'd500;
    pos_r = hit_r ? 9'(track) : 9'd500;
    serve = s;
    frame_tick = t;
    model(s, t, int'(pos_l), int'(pos_r));
    push_exp();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // One frame plus an idle cycle, with spot checks on the notable events.
  task automatic tick();
    old_x = m_x;
    step(1'b0, 1'b1);
    if (ev_top || ev_bot || ev_lhit || ev_lmiss || ev_rmiss) begin
      settle();
      if (ev_top) chk("top_bounce_y", int'(ball_y), 1);
      if (ev_bot) chk("bot_bounce_y", int'(ball_y), 473);
      if (ev_lhit) chk("lhit_x", int'(ball_x), old_x + 2);
      if ((ev_lmiss || ev_rmiss) && m_st == 1) begin
        chk("point_state", int'(state), 1);
        chk("point_en", int'(ball_en), 0);
        chk("point_x", int'(ball_x), 317);
        chk("point_y", int'(ball_y), 237);
      end
    end
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; serve = 1'b0; frame_tick = 1'b0;
    model_reset();
    push_exp();
    settle();
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(ball_x), 317);
    chk("rst_y", int'(ball_y), 237);
    chk("rst_en", int'(ball_en), 0);
    chk("rst_sl", int'(score_l), 0);
    chk("rst_sr", int'(score_r), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare each expectation once its update cycle has passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("sb_state", int'(state), e.st);
        chk("sb_ball_x", int'(ball_x), e.x);
        chk("sb_ball_y", int'(ball_y), e.y);
        chk("sb_ball_en", int'(ball_en), e.en);
        chk("sb_score_l", int'(score_l), e.sl);
        chk("sb_score_r", int'(score_r), e.sr);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    hit_l = 1; hit_r = 1;
    repeat (2) @(negedge clk);
    do_reset();

    // Serve coincident with a frame tick: the tick is not counted.
    step(1'b1, 1'b1);
    settle();
    chk("serve_state", int'(state), 1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) tick();
    step(1'b0, 1'b1);
    settle();
    chk("launch_state", int'(state), 2);
    chk("launch_en", int'(ball_en), 1);
    chk("launch_x", int'(ball_x), 317);
    chk("launch_y", int'(ball_y), 237);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    settle();
    chk("first_move_x", int'(ball_x), 319);
    chk("first_move_y", int'(ball_y), 238);
    step(1'b0, 1'b0);

    // Serve presses during play are ignored, with and without a tick.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Long rally: both paddles track the ball until every bounce kind is seen.
    n = 0;
    while (!(saw_top && saw_bot && saw_lhit && saw_rhit) && n < 3000) begin
      tick();
      n++;
    end
    total++;
    if (!(saw_top && saw_bot && saw_lhit && saw_rhit)) begin
      bad++;
      $display("FAIL rally_events: not all bounces reached within %0d frames", n);
    end

    // Points: right reaches 5 first, then left reaches 3.
    n = 0;
    while (!(m_sl >= 3 && m_sr >= 5 && m_st == 2) && n < 20000) begin
      hit_l = (m_sr >= 5);
      hit_r = (m_sl >= 3);
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) tick();
    settle();
    chk("pre_rst_sl", int'(score_l), 3);
    chk("pre_rst_sr", int'(score_r), 5);
    chk("pre_rst_state", int'(state), 2);
    do_reset();

    // Left player wins 9:0, then a serve restarts the game.
    hit_l = 1; hit_r = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n = 0;
    while (m_st != 3 && n < 20000) begin
      tick();
      n++;
    end
    settle();
    chk("win_state", int'(state), 3);
    chk("win_sl", int'(score_l), 9);
    chk("win_en", int'(ball_en), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("over_hold_sl", int'(score_l), 9);
    step(1'b1, 1'b0);
    settle();
    chk("restart_state", int'(state), 1);
    chk("restart_sl", int'(score_l), 0);
    chk("restart_sr", int'(score_r), 0);
    step(1'b0, 1'b0);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
